stack_register_p: RTL and testbench
===================================

STACK_REGISTER_P -- requirements
Module: stack_register_p

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bits per stack word (legal: 1 or more).
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of stack entries (legal: 2 or more).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_word  input  WIDTH  data word for PUSH, REPLACE and COLLAPSE.
REQ-006 SHALL have port mode  input  3  operation select, per REQ-012.
REQ-007 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-008 SHALL have port top_word  output  WIDTH  entry s[0].
REQ-009 SHALL have port second_word  output  WIDTH  entry s[1].
REQ-010 SHALL have port depth  output  $clog2(DEPTH+1)  count of valid entries, 0..DEPTH.
REQ-011 SHALL have ports empty, full, overflow, underflow  output  1 each  status flags; empty = (depth==0), full = (depth==DEPTH).

Function
REQ-012 SHALL decode mode as follows: 0 NOP; 1 PUSH; 2 POP; 3 REPLACE; 4 SWAP; 5 DUP; 6 OVER; 7 COLLAPSE.
REQ-013 SHALL hold storage s[0..DEPTH-1], with s[0] as top, and SHALL drive all outputs directly from registers, so each result is visible the cycle after the operative edge.
REQ-014 NOP SHALL leave all state unchanged.
REQ-015 PUSH SHALL shift s[i] to s[i+1], load s[0]=in_word, and increment depth.
REQ-016 PUSH when full SHALL discard s[DEPTH-1], keep depth=DEPTH, and set overflow.
REQ-017 POP SHALL shift s[i+1] to s[i], load s[DEPTH-1]=0, and decrement depth.
REQ-018 POP when empty SHALL leave storage and depth unchanged and set underflow.
REQ-019 REPLACE SHALL load s[0]=in_word without shifting; if empty, depth SHALL become 1.
REQ-020 SWAP SHALL exchange s[0] and s[1]; it requires depth>=2.
REQ-021 DUP SHALL push s[0]; it requires depth>=1. Full-stack behaviour SHALL match PUSH (REQ-016).
REQ-022 OVER SHALL push the pre-edge s[1]; it requires depth>=2. Full-stack behaviour SHALL match PUSH (REQ-016).
REQ-023 COLLAPSE SHALL load s[0]=in_word, shift s[i+2] to s[i+1], load s[DEPTH-1]=0, and decrement depth; it requires depth>=2. This is the ALU-result write-back: two operands popped, one result pushed.
REQ-024 When an operation's depth requirement is unmet, storage and depth SHALL be unchanged and underflow SHALL be set.
REQ-025 overflow and underflow SHALL be sticky until err_clr or rst.
REQ-026 If err_clr coincides with a new error, the flag SHALL read 1 after the edge; a set has priority over a clear.
REQ-027 Only entries below depth are meaningful, but vacated entries SHALL always read 0.
REQ-028 depth SHALL never wrap; it stays within 0..DEPTH in all cases.

Reset
REQ-029 rst=1 at a rising edge SHALL clear all s[i] to 0, depth to 0 and overflow/underflow to 0, giving empty=1 and full=0.
REQ-030 rst SHALL override any mode or err_clr in the same cycle, including mid-sequence; the next edge with rst=0 SHALL operate from the cleared state.

Verification
REQ-031 WIDTH=4, DEPTH=4: reset, then PUSH 3, PUSH 5 -> top_word=5, second_word=3, depth=2; then SWAP -> top_word=3, second_word=5.
REQ-032 PUSH 1,2,3,4 (full=1), then PUSH 9 -> overflow=1, depth=4, top_word=9, entry 1 discarded; POP x4 -> top_word sequence 4,3,2 then empty=1.
REQ-033 From reset, POP -> underflow=1, depth=0; then err_clr=1 with NOP -> underflow=0.
REQ-034 PUSH 6, PUSH 7, COLLAPSE in_word=D -> depth=1, top_word=D, second_word=0; then DUP -> top_word=D, second_word=D, depth=2.
REQ-035 With depth=1, SWAP and OVER each -> underflow=1 and state unchanged; with depth=3, assert rst together with PUSH -> depth=0, all outputs 0.

Source files
------------

// File: rtl/stack_register_p_if.sv
// Stack register bus: operation inputs and registered stack view.
interface stack_register_p_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_word;
    logic [2:0]       mode;
    logic             err_clr;
    logic [WIDTH-1:0] top_word;
    logic [WIDTH-1:0] second_word;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output in_word, mode, err_clr,
        input  top_word, second_word, depth,
        input  empty, full, overflow, underflow
    );

    modport slave (
        input  in_word, mode, err_clr,
        output top_word, second_word, depth,
        output empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_register_p.sv
// Shift-register operand stack with Forth-style ops and sticky error flags.
module stack_register_p #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               rst,
    stack_register_p_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [2:0] M_NOP  = 3'd0;
    localparam logic [2:0] M_PUSH = 3'd1;
    localparam logic [2:0] M_POP  = 3'd2;
    localparam logic [2:0] M_REPL = 3'd3;
    localparam logic [2:0] M_SWAP = 3'd4;
    localparam logic [2:0] M_DUP  = 3'd5;
    localparam logic [2:0] M_OVER = 3'd6;
    localparam logic [2:0] M_COLL = 3'd7;

    localparam logic [DW-1:0] D_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] D_ONE = DW'(1);
    localparam logic [DW-1:0] D_TWO = DW'(2);

    logic [DEPTH-1:0][WIDTH-1:0] s_q, s_n;
    logic [DW-1:0]               d_q, d_n;
    logic                        ov_q, un_q;
    logic                        empty_q, full_q;
    logic                        ov_set, un_set;
    logic                        push_en;
    logic [WIDTH-1:0]            push_val;

    always_comb begin
        s_n      = s_q;
        d_n      = d_q;
        ov_set   = 1'b0;
        un_set   = 1'b0;
        push_en  = 1'b0;
        push_val = '0;
        case (bus.mode)
            M_NOP: ;
            M_PUSH: begin
                push_en  = 1'b1;
                push_val = bus.in_word;
            end
            M_POP: begin
                if (d_q == '0) begin
                    un_set = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH - 1; i++)
                        s_n[i] = s_q[i+1];
                    s_n[DEPTH-1] = '0;
                    d_n          = d_q - D_ONE;
                end
            end
            M_REPL: begin
                s_n[0] = bus.in_word;
                if (d_q == '0)
                    d_n = D_ONE;
            end
            M_SWAP: begin
                if (d_q < D_TWO) begin
                    un_set = 1'b1;
                end else begin
                    s_n[0] = s_q[1];
                    s_n[1] = s_q[0];
                end
            end
            M_DUP: begin
                if (d_q == '0) begin
                    un_set = 1'b1;
                end else begin
                    push_en  = 1'b1;
                    push_val = s_q[0];
                end
            end
            M_OVER: begin
                if (d_q < D_TWO) begin
                    un_set = 1'b1;
                end else begin
                    push_en  = 1'b1;
                    push_val = s_q[1];
                end
            end
            M_COLL: begin
                if (d_q < D_TWO) begin
                    un_set = 1'b1;
                end else begin
                    s_n[0] = bus.in_word;
                    for (int i = 1; i < DEPTH - 1; i++)
                        s_n[i] = s_q[i+1];
                    s_n[DEPTH-1] = '0;
                    d_n          = d_q - D_ONE;
                end
            end
            default: ;
        endcase

        // A push onto a full stack drops the bottom entry
        if (push_en) begin
            for (int i = DEPTH - 1; i > 0; i--)
                s_n[i] = s_q[i-1];
            s_n[0] = push_val;
            if (d_q == D_MAX)
                ov_set = 1'b1;
            else
                d_n = d_q + D_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            d_q     <= '0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            s_q     <= s_n;
            d_q     <= d_n;
            ov_q    <= ov_set | (ov_q & ~bus.err_clr);
            un_q    <= un_set | (un_q & ~bus.err_clr);
            empty_q <= (d_n == '0);
            full_q  <= (d_n == D_MAX);
        end
    end

    assign bus.top_word    = s_q[0];
    assign bus.second_word = s_q[1];
    assign bus.depth       = d_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.overflow    = ov_q;
    assign bus.underflow   = un_q;
endmodule

// File: tb/tb_stack_register_p.sv
// Directed vector table plus random ops checked against a queue model.
module tb_stack_register_p;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        string      nm;
        logic       rst;
        logic [2:0] mode;
        logic [3:0] din;
        logic       clr;
        logic [3:0] top;
        logic [3:0] sec;
        logic [2:0] dep;
        logic       emp;
        logic       ful;
        logic       ov;
        logic       un;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    stack_register_p_if #(.WIDTH(W), .DEPTH(D)) bus ();

    stack_register_p #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t tbl[$];

    logic [3:0] q[$];
    logic       m_ov, m_un;

    function automatic vec_t v(string nm, logic r, logic [2:0] m,
                               logic [3:0] di, logic c, logic [3:0] t,
                               logic [3:0] s, logic [2:0] dp, logic e,
                               logic f, logic o, logic u);
        vec_t x;
        x.nm = nm; x.rst = r; x.mode = m; x.din = di; x.clr = c;
        x.top = t; x.sec = s; x.dep = dp; x.emp = e; x.ful = f;
        x.ov = o; x.un = u;
        return x;
    endfunction

    task automatic apply(logic r, logic [2:0] m, logic [3:0] di, logic c);
        rst         = r;
        bus.mode    = m;
        bus.in_word = di;
        bus.err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [3:0] t, logic [3:0] s,
                       logic [2:0] dp, logic e, logic f, logic o, logic u);
        total++;
        if ({bus.top_word, bus.second_word, bus.depth, bus.empty,
             bus.full, bus.overflow, bus.underflow} !==
            {t, s, dp, e, f, o, u}) begin
            $display("FAIL %s: got top=%0h sec=%0h dep=%0d e=%b f=%b ov=%b un=%b want top=%0h sec=%0h dep=%0d e=%b f=%b ov=%b un=%b",
                     nm, bus.top_word, bus.second_word, bus.depth,
                     bus.empty, bus.full, bus.overflow, bus.underflow,
                     t, s, dp, e, f, o, u);
        end else begin
            passed++;
        end
    endtask

    task automatic model(logic r, logic [2:0] m, logic [3:0] di, logic c);
        logic [3:0] a;
        logic       os, us;
        os = 1'b0;
        us = 1'b0;
        if (r) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            return;
        end
        case (m)
            3'd1: q.push_front(di);
            3'd2: if (q.size() == 0) us = 1'b1; else a = q.pop_front();
            3'd3: if (q.size() == 0) q.push_front(di); else q[0] = di;
            3'd4: if (q.size() < 2) us = 1'b1;
                  else begin a = q[0]; q[0] = q[1]; q[1] = a; end
            3'd5: if (q.size() < 1) us = 1'b1; else begin a = q[0]; q.push_front(a); end
            3'd6: if (q.size() < 2) us = 1'b1; else begin a = q[1]; q.push_front(a); end
            3'd7: if (q.size() < 2) us = 1'b1;
                  else begin a = q.pop_front(); a = q.pop_front(); q.push_front(di); end
            default: ;
        endcase
        if (q.size() > D) begin
            a  = q.pop_back();
            os = 1'b1;
        end
        m_ov = os | (m_ov & ~c);
        m_un = us | (m_un & ~c);
    endtask

    initial begin
        logic       r, c;
        logic [2:0] m;
        logic [3:0] di, et, es;

        bus.mode = 3'd0; bus.in_word = 4'd0; bus.err_clr = 1'b0;

        tbl.push_back(v("reset",      1,0,0,0, 0,0,0,1,0,0,0));
        tbl.push_back(v("push3",      0,1,3,0, 3,0,1,0,0,0,0));
        tbl.push_back(v("push5",      0,1,5,0, 5,3,2,0,0,0,0));
        tbl.push_back(v("swap",       0,4,0,0, 3,5,2,0,0,0,0));
        tbl.push_back(v("reset2",     1,1,7,1, 0,0,0,1,0,0,0));
        tbl.push_back(v("push1",      0,1,1,0, 1,0,1,0,0,0,0));
        tbl.push_back(v("push2",      0,1,2,0, 2,1,2,0,0,0,0));
        tbl.push_back(v("push3b",     0,1,3,0, 3,2,3,0,0,0,0));
        tbl.push_back(v("push4_full", 0,1,4,0, 4,3,4,0,1,0,0));
        tbl.push_back(v("push9_ovf",  0,1,9,0, 9,4,4,0,1,1,0));
        tbl.push_back(v("pop_a",      0,2,0,0, 4,3,3,0,0,1,0));
        tbl.push_back(v("pop_b",      0,2,0,0, 3,2,2,0,0,1,0));
        tbl.push_back(v("pop_c",      0,2,0,0, 2,0,1,0,0,1,0));
        tbl.push_back(v("pop_d",      0,2,0,0, 0,0,0,1,0,1,0));
        tbl.push_back(v("clr_ovf",    0,0,0,1, 0,0,0,1,0,0,0));
        tbl.push_back(v("pop_empty",  0,2,0,0, 0,0,0,1,0,0,1));
        tbl.push_back(v("clr_unf",    0,0,0,1, 0,0,0,1,0,0,0));
        tbl.push_back(v("pop_clr_set",0,2,0,1, 0,0,0,1,0,0,1));
        tbl.push_back(v("clr_unf2",   0,0,0,1, 0,0,0,1,0,0,0));
        tbl.push_back(v("push6",      0,1,6,0, 6,0,1,0,0,0,0));
        tbl.push_back(v("push7",      0,1,7,0, 7,6,2,0,0,0,0));
        tbl.push_back(v("collapse",   0,7,13,0, 13,0,1,0,0,0,0));
        tbl.push_back(v("dup",        0,5,0,0, 13,13,2,0,0,0,0));
        tbl.push_back(v("over",       0,6,0,0, 13,13,3,0,0,0,0));
        tbl.push_back(v("reset3",     1,0,0,0, 0,0,0,1,0,0,0));
        tbl.push_back(v("repl_empty", 0,3,7,0, 7,0,1,0,0,0,0));
        tbl.push_back(v("repl",       0,3,8,0, 8,0,1,0,0,0,0));
        tbl.push_back(v("swap_d1",    0,4,0,0, 8,0,1,0,0,0,1));
        tbl.push_back(v("clr_unf3",   0,0,0,1, 8,0,1,0,0,0,0));
        tbl.push_back(v("over_d1",    0,6,0,0, 8,0,1,0,0,0,1));
        tbl.push_back(v("coll_d1",    0,7,5,1, 8,0,1,0,0,0,1));
        tbl.push_back(v("push_x",     0,1,3,0, 3,8,2,0,0,0,1));
        tbl.push_back(v("push_y",     0,1,4,0, 4,3,3,0,0,0,1));
        tbl.push_back(v("rst_w_push", 1,1,5,1, 0,0,0,1,0,0,0));
        tbl.push_back(v("post_rst",   0,1,1,0, 1,0,1,0,0,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].mode, tbl[i].din, tbl[i].clr);
            chk(tbl[i].nm, tbl[i].top, tbl[i].sec, tbl[i].dep,
                tbl[i].emp, tbl[i].ful, tbl[i].ov, tbl[i].un);
        end

        apply(1'b1, 3'd0, 4'd0, 1'b0);
        model(1'b1, 3'd0, 4'd0, 1'b0);
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 39) == 0);
            m  = 3'($urandom_range(0, 7));
            di = 4'($urandom_range(0, 15));
            c  = ($urandom_range(0, 7) == 0);
            apply(r, m, di, c);
            model(r, m, di, c);
            et = (q.size() > 0) ? q[0] : 4'd0;
            es = (q.size() > 1) ? q[1] : 4'd0;
            chk("random", et, es, 3'(q.size()), q.size() == 0,
                q.size() == D, m_ov, m_un);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
